pll_reset_sequencer: RTL and testbench

- Sits directly upstream of the iCE40 PLL wrapper and runs on the 12 MHz reference clock.
- Drives the PLL's active-low RESETB, watches the PLL LOCK output, and enforces a minimum reset pulse, a lock timeout with bounded retries, and a post-lock settle interval.
- Only after all of that does it release the system reset consumed by the PLL-clocked logic.
- Reports a sticky fault if the PLL never locks.

---
 rtl/pll_seq_pkg.sv | 36 +++
 rtl/sync_ff.sv | 33 +++
 rtl/pll_reset_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer:
//   - seq_state_t : one-hot sequencer state encoding
//   - cnt_width() : width of the shared interval down-counter
//   - DEF_*       : default interval/retry constants for a 12 MHz reference
// -----------------------------------------------------------------------------
package pll_seq_pkg;

   // One-hot so that any corrupted pattern is trivially detectable and lands
   // in the default branch of the next-state logic.
   typedef enum logic [4:0] {
      ST_HOLD      = 5'b00001,
      ST_WAIT_LOCK = 5'b00010,
      ST_SETTLE    = 5'b00100,
      ST_RUN       = 5'b01000,
      ST_FAULT     = 5'b10000
   } seq_state_t;

   // Defaults for a 12 MHz REFERENCECLK.
   localparam int DEF_HOLD_CYCLES   = 12;     // 1 us
   localparam int DEF_LOCK_TIMEOUT  = 12000;  // 1 ms
   localparam int DEF_SETTLE_CYCLES = 1200;   // 100 us
   localparam int DEF_MAX_RETRIES   = 3;
   localparam int DEF_SYNC_STAGES   = 2;

   // clog2 of the largest interval, plus one bit of headroom.
   function automatic int cnt_width(input int hold_c, input int lock_c, input int settle_c);
      int m;
      m = hold_c;
      if (lock_c > m)   m = lock_c;
      if (settle_c > m) m = settle_c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop single-bit synchronizer with asynchronous active-low clear.
// Used for the PLL LOCK input here and for the SYS_RESET_N re-sync on the
// PLL-clocked side.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : async active-low clear (all stages to 0)
//   i_d     : asynchronous input bit
//   o_q     : synchronized output, lags i_d by STAGES clock edges
// -----------------------------------------------------------------------------
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Drives the iCE40 PLL RESETB, watches LOCK, and releases the system reset for
// PLL-clocked logic only after a minimum reset pulse, a successful lock within
// a timeout (with bounded retries) and a continuous post-lock settle interval.
// Parks the PLL and raises a sticky FAULT if it never locks.
// Ports:
//   REFERENCECLK : 12 MHz reference clock, the only clock
//   RESET        : async active-low reset
//   LOCK         : PLL lock, asynchronous to REFERENCECLK
//   REARM        : single-cycle pulse, leaves FAULT and restarts the sequence
//   PLL_RESETB   : PLL RESETB, active low
//   SYS_RESET_N  : active-low system reset for PLL-domain logic
//   LOCKED       : synchronized LOCK
//   FAULT        : high while in the FAULT state
//   RETRY_COUNT  : failed lock attempts in the current sequence
// -----------------------------------------------------------------------------
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic       REFERENCECLK,
   input  logic       RESET,
   input  logic       LOCK,
   input  logic       REARM,
   output logic       PLL_RESETB,
   output logic       SYS_RESET_N,
   output logic       LOCKED,
   output logic       FAULT,
   output logic [3:0] RETRY_COUNT
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

   seq_state_t       r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic             r_cnt_en;
   logic [3:0]       r_retry, w_retry_next;
   logic [3:0]       w_retry_inc;
   logic             r_pll_resetb, w_pll_resetb_next;
   logic             r_sys_reset_n, w_sys_reset_n_next;
   logic             r_fault, w_fault_next;
   logic             w_locked;
   logic             w_terminal;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .i_clk   (REFERENCECLK),
      .i_rst_n (RESET),
      .i_d     (LOCK),
      .o_q     (w_locked)
   );

   // The counter comes out of reset at 0 but un-armed: the first HOLD cycle
   // after reset loads HOLD_LOAD instead of firing, so the very first
   // PLL_RESETB pulse is as long as every later one. Every other state entry
   // loads the counter on the transition edge itself.
   assign w_terminal  = r_cnt_en && (r_cnt == '0);
   assign w_retry_inc = r_retry + 4'd1;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_retry_next = r_retry;

      case (r_state)
         ST_HOLD: begin
            if (!r_cnt_en) begin
               w_cnt_next = HOLD_LOAD;
            end else if (w_terminal) begin
               w_state_next = ST_WAIT_LOCK;
               w_cnt_next   = WAIT_LOAD;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end

         ST_WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout.
            if (w_locked) begin
               w_state_next = ST_SETTLE;
               w_cnt_next   = SETTLE_LOAD;
            end else if (w_terminal) begin
               w_retry_next = w_retry_inc;
               if (w_retry_inc == RETRY_LIMIT) begin
                  w_state_next = ST_FAULT;
                  w_cnt_next   = '0;
               end else begin
                  w_state_next = ST_HOLD;
                  w_cnt_next   = HOLD_LOAD;
               end
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end

         ST_SETTLE: begin
            // Any drop of lock restarts the wait; it does not count as a retry.
            if (!w_locked) begin
               w_state_next = ST_WAIT_LOCK;
               w_cnt_next   = WAIT_LOAD;
            end else if (w_terminal) begin
               w_state_next = ST_RUN;
               w_cnt_next   = '0;
               w_retry_next = 4'd0;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end

         ST_RUN: begin
            if (!w_locked) begin
               w_state_next = ST_HOLD;
               w_cnt_next   = HOLD_LOAD;
            end
         end

         ST_FAULT: begin
            if (REARM) begin
               w_state_next = ST_HOLD;
               w_cnt_next   = HOLD_LOAD;
               w_retry_next = 4'd0;
            end
         end

         default: begin
            w_state_next = ST_HOLD;
            w_cnt_next   = HOLD_LOAD;
         end
      endcase

      // Outputs are decoded from the next state and registered alongside it,
      // so they change on the same edge as the state and never glitch.
      w_pll_resetb_next  = !((w_state_next == ST_HOLD) || (w_state_next == ST_FAULT));
      w_sys_reset_n_next = (w_state_next == ST_RUN);
      w_fault_next       = (w_state_next == ST_FAULT);
   end

   always_ff @(posedge REFERENCECLK or negedge RESET) begin
      if (!RESET) begin
         r_state       <= ST_HOLD;
         r_cnt         <= '0;
         r_cnt_en      <= 1'b0;
         r_retry       <= 4'd0;
         r_pll_resetb  <= 1'b0;
         r_sys_reset_n <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_cnt         <= w_cnt_next;
         r_cnt_en      <= 1'b1;
         r_retry       <= w_retry_next;
         r_pll_resetb  <= w_pll_resetb_next;
         r_sys_reset_n <= w_sys_reset_n_next;
         r_fault       <= w_fault_next;
      end
   end

   assign PLL_RESETB  = r_pll_resetb;
   assign SYS_RESET_N = r_sys_reset_n;
   assign LOCKED      = w_locked;
   assign FAULT       = r_fault;
   assign RETRY_COUNT = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Directed bench for pll_reset_sequencer with HOLD=4, TIMEOUT=20, SETTLE=8,
// MAX_RETRIES=2, SYNC_STAGES=2. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   localparam int HOLD_C   = 4;
   localparam int TIMEOUT  = 20;
   localparam int SETTLE_C = 8;
   localparam int RETRIES  = 2;
   localparam int SYNC_N   = 2;
   localparam int LATENCY  = SYNC_N + SETTLE_C + 1;  // LOCK rise -> SYS_RESET_N rise
   localparam int BOUND    = 200;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lock = 1'b0;
   logic       rearm = 1'b0;
   logic       pll_resetb;
   logic       sys_reset_n;
   logic       locked;
   logic       fault;
   logic [3:0] retry;

   int n_checks = 0;
   int n_pass   = 0;
   int n;
   int sys_seen;

   always #5 clk = ~clk;

   pll_reset_sequencer #(
      .HOLD_CYCLES   (HOLD_C),
      .LOCK_TIMEOUT  (TIMEOUT),
      .SETTLE_CYCLES (SETTLE_C),
      .MAX_RETRIES   (RETRIES),
      .SYNC_STAGES   (SYNC_N)
   ) dut (
      .REFERENCECLK (clk),
      .RESET        (rst_n),
      .LOCK         (lock),
      .REARM        (rearm),
      .PLL_RESETB   (pll_resetb),
      .SYS_RESET_N  (sys_reset_n),
      .LOCKED       (locked),
      .FAULT        (fault),
      .RETRY_COUNT  (retry)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
         $display("ok   %-24s got %0d", tag, got);
      end else begin
         $display("FAIL %-24s got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Counts consecutive samples (including the current one) at which
   // PLL_RESETB equals lvl; returns on the first sample where it differs.
   task automatic count_level(input logic lvl, output int cnt);
      cnt = 0;
      while (pll_resetb === lvl && cnt < BOUND) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   // Counts falling edges until SYS_RESET_N equals lvl.
   task automatic cycles_until_sys(input logic lvl, output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (sys_reset_n !== lvl && cnt < BOUND);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      lock  = 1'b0;
      rearm = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_rearm();
      rearm = 1'b1;
      @(negedge clk);
      rearm = 1'b0;
   endtask

   initial begin
      // ---- reset state (LOCK high during reset must not reach LOCKED) ----
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      lock = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst pll_resetb", pll_resetb, 0);
      check_eq("rst sys_reset_n", sys_reset_n, 0);
      check_eq("rst locked", locked, 0);
      check_eq("rst fault", fault, 0);
      check_eq("rst retry", retry, 0);

      // ---- clean start ----
      lock  = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      count_level(1'b0, n);
      check_eq("s1 hold width", n, HOLD_C);
      repeat (10) @(negedge clk);
      lock = 1'b1;
      cycles_until_sys(1'b1, n);
      check_eq("s1 lock->sys latency", n, LATENCY);
      check_eq("s1 retry", retry, 0);
      check_eq("s1 locked", locked, 1);
      check_eq("s1 pll_resetb", pll_resetb, 1);
      // REARM outside FAULT must do nothing
      pulse_rearm();
      repeat (3) @(negedge clk);
      check_eq("s1 rearm ignored sys", sys_reset_n, 1);
      check_eq("s1 rearm ignored pll", pll_resetb, 1);

      // ---- single timeout ----
      do_reset();
      count_level(1'b0, n);
      check_eq("s2 hold1 width", n, HOLD_C);
      count_level(1'b1, n);
      check_eq("s2 timeout width", n, TIMEOUT);
      check_eq("s2 retry after timeout", retry, 1);
      count_level(1'b0, n);
      check_eq("s2 hold2 width", n, HOLD_C);
      repeat (4) @(negedge clk);
      lock = 1'b1;
      check_eq("s2 retry in wait", retry, 1);
      cycles_until_sys(1'b1, n);
      check_eq("s2 lock->sys latency", n, LATENCY);
      check_eq("s2 retry in run", retry, 0);

      // ---- fault and rearm ----
      do_reset();
      count_level(1'b0, n);
      count_level(1'b1, n);
      count_level(1'b0, n);
      count_level(1'b1, n);
      check_eq("s3 second timeout", n, TIMEOUT);
      check_eq("s3 fault", fault, 1);
      check_eq("s3 pll parked", pll_resetb, 0);
      check_eq("s3 retry", retry, RETRIES);
      check_eq("s3 sys", sys_reset_n, 0);
      lock = 1'b1;
      repeat (30) @(negedge clk);
      check_eq("s3 fault sticky", fault, 1);
      check_eq("s3 pll still parked", pll_resetb, 0);
      lock = 1'b0;
      repeat (3) @(negedge clk);
      pulse_rearm();
      check_eq("s3 fault cleared", fault, 0);
      check_eq("s3 retry cleared", retry, 0);
      count_level(1'b0, n);
      check_eq("s3 hold after rearm", n, HOLD_C);
      lock = 1'b1;
      cycles_until_sys(1'b1, n);
      check_eq("s3 lock->sys latency", n, LATENCY);

      // ---- glitch in SETTLE ----
      do_reset();
      count_level(1'b0, n);
      lock = 1'b1;
      sys_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (sys_reset_n) sys_seen = 1;
      end
      lock = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (sys_reset_n || !pll_resetb) sys_seen = 1;
      end
      lock = 1'b1;
      cycles_until_sys(1'b1, n);
      check_eq("s4 sys/pll during glitch", sys_seen, 0);
      check_eq("s4 relock->sys latency", n, LATENCY);
      check_eq("s4 retry unchanged", retry, 0);

      // ---- lock loss in RUN ----
      lock = 1'b0;
      cycles_until_sys(1'b0, n);
      check_eq("s5 loss->sys low", n, SYNC_N + 1);
      count_level(1'b0, n);
      check_eq("s5 hold width", n, HOLD_C);
      lock = 1'b1;
      cycles_until_sys(1'b1, n);
      check_eq("s5 relock->sys latency", n, LATENCY);

      // ---- reset during SETTLE ----
      do_reset();
      count_level(1'b0, n);
      lock = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("s6 locked in settle", locked, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("s6 async pll", pll_resetb, 0);
      check_eq("s6 async sys", sys_reset_n, 0);
      check_eq("s6 async locked", locked, 0);
      check_eq("s6 async retry", retry, 0);
      lock = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      count_level(1'b0, n);
      check_eq("s6 restart hold", n, HOLD_C);

      // ---- reset during FAULT ----
      count_level(1'b1, n);
      count_level(1'b0, n);
      count_level(1'b1, n);
      check_eq("s7 fault", fault, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("s7 async fault", fault, 0);
      check_eq("s7 async retry", retry, 0);
      check_eq("s7 async pll", pll_resetb, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      count_level(1'b0, n);
      check_eq("s7 restart hold", n, HOLD_C);
      count_level(1'b1, n);
      check_eq("s7 restart timeout", n, TIMEOUT);
      check_eq("s7 retry restarted", retry, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
